// File: rtl/riscv_pkg.sv
// Shared pipeline types: memory access sizes and the data-memory responder FSM states.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_WAIT = 2'b01,
        DMEM_RESP = 2'b10
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        mem_size_t   size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic misaligned(input mem_size_t size, input logic [1:0] lane);
        case (size)
            MEM_HALF: return lane[0];
            MEM_WORD: return lane != 2'b00;
            MEM_RSVD: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the memory stage and the data memory.
interface data_mem_responder_if;
    import riscv_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables/replicated data and load extract/extend.
// Misalignment checking is compiled in with DMEM_MISALIGN_CHK_EN.
module dmem_lane_align
    import riscv_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        err
);

    mem_size_t   eff_size;
    logic [1:0]  eff_lane;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        eff_size = (size == MEM_RSVD) ? MEM_WORD : size;
        eff_lane = 2'b00;
        case (eff_size)
            MEM_BYTE: eff_lane = lane;
            MEM_HALF: eff_lane = {lane[1], 1'b0};
            default:  eff_lane = 2'b00;
        endcase
        shifted  = rword >> {eff_lane, 3'b000};

        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = '0;
        case (eff_size)
            MEM_BYTE: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be       = 4'b1111;
                wdata_sh = wdata;
                rdata    = rword;
            end
        endcase

`ifdef DMEM_MISALIGN_CHK_EN
        // A faulting access must neither write nor leak RAM contents.
        err = misaligned(size, lane);
        if (err) begin
            be    = 4'b0000;
            rdata = '0;
        end
`else
        err = 1'b0;
`endif
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave: one request at a time, WAIT_CYCLES wait states, valid/ready response.
// Optional misalignment errors with DMEM_MISALIGN_CHK_EN.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t       state, next_state;
    dmem_req_t         req_q, cur_req;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept, commit;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rword;
    logic [3:0]        be;
    logic [31:0]       wdata_sh, al_rdata;
    logic              al_err;
    logic              unused_addr_hi;

    logic [31:0] mem [DEPTH];

    assign accept = bus.req_valid && (state == DMEM_IDLE);

    // With zero wait states the commit happens on the accept edge, so use the live bus fields.
    always_comb begin
        cur_req = req_q;
        if (state == DMEM_IDLE) begin
            cur_req.we          = bus.req_we;
            cur_req.size        = bus.req_size;
            cur_req.is_unsigned = bus.req_unsigned;
            cur_req.addr        = bus.req_addr;
            cur_req.wdata       = bus.req_wdata;
        end
    end

    assign idx            = cur_req.addr[ADDR_W+1:2];
    assign rword          = mem[idx];
    assign unused_addr_hi = ^cur_req.addr[31:ADDR_W+2];

    dmem_lane_align u_align (
        .size        (cur_req.size),
        .lane        (cur_req.addr[1:0]),
        .is_unsigned (cur_req.is_unsigned),
        .wdata       (cur_req.wdata),
        .rword       (rword),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata       (al_rdata),
        .err         (al_err)
    );

    always_comb begin
        next_state = state;
        case (state)
            DMEM_IDLE: if (accept) next_state = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
            DMEM_WAIT: if (wait_cnt == '0) next_state = DMEM_RESP;
            DMEM_RESP: if (bus.rsp_ready) next_state = DMEM_IDLE;
            default:   next_state = DMEM_IDLE;
        endcase
    end

    assign commit = !rst && (state != DMEM_RESP) && (next_state == DMEM_RESP);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DMEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                req_q    <= cur_req;
                wait_cnt <= WAIT_LOAD;
            end else if (state == DMEM_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (commit) begin
                rdata_q <= cur_req.we ? 32'h0 : al_rdata;
                err_q   <= al_err;
            end
        end
    end

    // NOTE: the RAM array has no reset; only the control path is cleared by rst.
    always_ff @(posedge clk) begin
        if (commit && cur_req.we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state == DMEM_IDLE);
    assign bus.rsp_valid = (state == DMEM_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=0.
module tb_data_mem_responder;
    import riscv_pkg::*;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    logic        sel;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    mem_size_t   req_size;
    logic [31:0] req_addr, req_wdata;
    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    assign bus1.req_valid    = req_valid & sel;
    assign bus0.req_valid    = req_valid & ~sel;
    assign bus1.req_we       = req_we;
    assign bus0.req_we       = req_we;
    assign bus1.req_size     = req_size;
    assign bus0.req_size     = req_size;
    assign bus1.req_unsigned = req_unsigned;
    assign bus0.req_unsigned = req_unsigned;
    assign bus1.req_addr     = req_addr;
    assign bus0.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;
    assign bus0.req_wdata    = req_wdata;
    assign bus1.rsp_ready    = rsp_ready;
    assign bus0.rsp_ready    = rsp_ready;

    assign m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
    assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign m_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign m_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        sel;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic we, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                                input logic [3:0] lat);
        vec_t v;
        v.sel = s; v.we = we; v.size = sz; v.uns = u;
        v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_lat = lat;
        return v;
    endfunction

    // One complete transaction with rsp_ready held high; lat counts edges from accept to rsp_valid.
    task automatic do_req(input logic s, input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        sel = s; req_we = we; req_size = mem_size_t'(sz); req_unsigned = u;
        req_addr = a; req_wdata = wd; req_valid = 1'b1; rsp_ready = 1'b1;
        guard = 0;
        while (!m_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!m_rsp_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rd = m_rsp_rdata;
        er = m_rsp_err;
        @(posedge clk);
    endtask

    vec_t vecs[20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;
        logic [31:0] held;

        vecs[0]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        4'd2);
        vecs[1]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 4'd2);
        vecs[2]  = mk(1'b1, 1'b1, 2'b00, 1'b0, 32'h12,   32'h12345680, 32'h0,        4'd2);
        vecs[3]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h12,   32'h0,        32'hFFFFFF80, 4'd2);
        vecs[4]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h12,   32'h0,        32'h00000080, 4'd2);
        vecs[5]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDE80BEEF, 4'd2);
        vecs[6]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h14,   32'hA5A5A5A5, 32'h0,        4'd2);
        vecs[7]  = mk(1'b1, 1'b1, 2'b01, 1'b0, 32'h16,   32'h77778001, 32'h0,        4'd2);
        vecs[8]  = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h16,   32'h0,        32'hFFFF8001, 4'd2);
        vecs[9]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h16,   32'h0,        32'h00008001, 4'd2);
        vecs[10] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h14,   32'h0,        32'h8001A5A5, 4'd2);
        vecs[11] = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h15,   32'h0,        32'h000000A5, 4'd2);
        vecs[12] = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'hFFFFFFDE, 4'd2);
        vecs[13] = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        32'h000000BE, 4'd2);
        vecs[14] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, 32'h0,        4'd2);
        vecs[15] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0,    32'h0,        32'h12345678, 4'd2);
        vecs[16] = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h20,   32'hCAFEF00D, 32'h0,        4'd1);
        vecs[17] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h20,   32'h0,        32'hFFFFF00D, 4'd1);
        vecs[18] = mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        32'h0000CAFE, 4'd1);
        vecs[19] = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h23,   32'h0,        32'hFFFFFFCA, 4'd1);

        // Reset state, observed before any clock edge.
        rst = 1'b1; sel = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = MEM_WORD;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #2;
        check("reset_req_ready1", {31'b0, bus1.req_ready}, 32'd1);
        check("reset_rsp_valid1", {31'b0, bus1.rsp_valid}, 32'd0);
        check("reset_rsp_rdata1", bus1.rsp_rdata, 32'h0);
        check("reset_rsp_err1",   {31'b0, bus1.rsp_err}, 32'd0);
        check("reset_req_ready0", {31'b0, bus0.req_ready}, 32'd1);
        check("reset_rsp_valid0", {31'b0, bus0.rsp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(vecs[i].sel, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, er}, 32'd0);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Backpressure: response held for 5 cycles with rsp_ready low.
        @(negedge clk);
        sel = 1'b1; req_we = 1'b0; req_size = MEM_WORD; req_unsigned = 1'b0;
        req_addr = 32'h14; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!m_rsp_valid && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        held = m_rsp_rdata;
        check("bp_rdata", held, 32'h8001A5A5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), {31'b0, m_rsp_valid}, 32'd1);
            check($sformatf("bp%0d_rdata", k), m_rsp_rdata, 32'h8001A5A5);
            check($sformatf("bp%0d_req_ready", k), {31'b0, m_req_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("bp_release_valid", {31'b0, m_rsp_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_done_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        check("bp_done_req_ready", {31'b0, m_req_ready}, 32'd1);

        // Misaligned and reserved-size accesses.
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, er, lat);
        check("lw13_err", {31'b0, er}, {31'b0, CHK});
        check("lw13_rdata", rd, CHK ? 32'h0 : 32'hDE80BEEF);
        check("lw13_latency", 32'(lat), 32'd2);
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h17, 32'h0, rd, er, lat);
        check("lh17_err", {31'b0, er}, {31'b0, CHK});
        check("lh17_rdata", rd, CHK ? 32'h0 : 32'hFFFF8001);
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, rd, er, lat);
        check("rsvd14_err", {31'b0, er}, {31'b0, CHK});
        check("rsvd14_rdata", rd, CHK ? 32'h0 : 32'h8001A5A5);
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFFFFFF, rd, er, lat);
        check("sw11_err", {31'b0, er}, {31'b0, CHK});
        check("sw11_rdata", rd, 32'h0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("lw10_after_sw11", rd, CHK ? 32'hDE80BEEF : 32'hFFFFFFFF);

        // Reset during WAIT drops the uncommitted store; the committed one persists.
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, rd, er, lat);
        @(negedge clk);
        sel = 1'b1; req_we = 1'b1; req_size = MEM_WORD; req_addr = 32'h40;
        req_wdata = 32'h22222222; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_in_wait", {31'b0, m_req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_req_ready", {31'b0, m_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        check("post_rst_req_ready", {31'b0, m_req_ready}, 32'd1);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        check("lw40_after_rst", rd, 32'h11111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
